hilo_muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit that sits directly downstream of the ALU decoder. It consumes the MULTUac/DIVUac ALU control codes and owns the architectural HI/LO registers. Those registers feed the SEL_RESULT_MFHI and SEL_RESULT_MFLO result-mux inputs. It runs one radix-2 step per cycle and exposes busy/done so the pipeline can stall MFHI/MFLO and new mul/div issues.

---
 rtl/hilo_muldiv_unit.sv | 129 ++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative unsigned MULTU/DIVU unit owning the HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [3:0] MULTU_AC = 4'd7;
    localparam logic [3:0] DIVU_AC  = 4'd8;
    localparam int         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] op_b;
    logic             dz_pend;
    logic             accept;

    // Shared working pair: MUL keeps partial product / multiplier, DIV keeps remainder / quotient
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH:0]   div_rem_n;
    logic [WIDTH-1:0] div_q_n;

    always_comb begin
        mul_sum   = {1'b0, work_hi[WIDTH-1:0]} + (work_lo[0] ? {1'b0, op_b} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], work_lo[WIDTH-1:1]};
        div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, op_b};
        div_rem_n = div_ge ? (div_shift - {1'b0, op_b}) : div_shift;
        div_q_n   = {work_lo[WIDTH-2:0], div_ge};
    end

    assign accept = start && ((state == IDLE) || (state == DONE)) &&
                    ((alu_ctrl == MULTU_AC) || (alu_ctrl == DIVU_AC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            op_b        <= '0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        work_hi     <= '0;
                        if (alu_ctrl == MULTU_AC) begin
                            state   <= MUL;
                            op_b    <= a;
                            work_lo <= b;
                            dz_pend <= 1'b0;
                        end else begin
                            state   <= DIV;
                            op_b    <= b;
                            work_lo <= a;
                            dz_pend <= (b == '0);
                        end
                    end
                end
                MUL: begin
                    cnt     <= cnt + 1'b1;
                    work_hi <= {1'b0, mul_hi_n};
                    work_lo <= mul_lo_n;
                    if (cnt == LAST) begin
                        hi    <= mul_hi_n;
                        lo    <= mul_lo_n;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DIV: begin
                    if (dz_pend) begin
                        hi          <= work_lo;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        work_hi <= div_rem_n;
                        work_lo <= div_q_n;
                        if (cnt == LAST) begin
                            hi    <= div_rem_n[WIDTH-1:0];
                            lo    <= div_q_n;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

    localparam logic [3:0] MULTU_AC = 4'd7;
    localparam logic [3:0] DIVU_AC  = 4'd8;
    localparam logic [3:0] ADD_AC   = 4'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu_ctrl = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result checks happen when the DUT pulses done
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("div_by_zero", div_by_zero, e.dz);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a rising edge; the op is accepted on the next edge
    task automatic issue(input logic [3:0] ctrl, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        if (ctrl == MULTU_AC) begin
            p    = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.cyc = cyc + 1 + 32;
        end else if (y == 0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
            e.cyc = cyc + 1 + 1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.dz = 1'b0;
            e.cyc = cyc + 1 + 32;
        end
        sb.push_back(e);
        start = 1'b1; alu_ctrl = ctrl; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        check("busy_after_accept", busy, 1);
        check("done_clear_at_accept", done, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Max multiply
        issue(MULTU_AC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        @(posedge clk); #1;
        check("busy_idle", busy, 0);
        check("done_one_cycle", done, 0);

        // Basic divide, then a<b issued on the done cycle
        issue(DIVU_AC, 32'd100, 32'd7);
        wait_done();
        issue(DIVU_AC, 32'd5, 32'd9);
        wait_done();
        @(posedge clk); #1;

        // Divide by zero, then MULTU clears the flag at accept
        issue(DIVU_AC, 32'h1234_5678, 32'd0);
        wait_done();
        @(posedge clk); #1;
        issue(MULTU_AC, 32'd3, 32'd4);
        check("dz_cleared", div_by_zero, 0);
        wait_done();
        @(posedge clk); #1;

        // Start during busy is ignored
        issue(MULTU_AC, 32'd2, 32'd3);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; alu_ctrl = MULTU_AC; a = 32'd50; b = 32'd50;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        @(posedge clk); #1;

        // Non mul/div code is ignored
        start = 1'b1; alu_ctrl = ADD_AC; a = 32'd9; b = 32'd9;
        @(posedge clk); #1 start = 1'b0;
        check("add_no_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 check("add_no_done", done, 0);
        check("add_lo_held", lo, 32'd6);

        // HI/LO hold previous result during a DIVU
        issue(MULTU_AC, 32'd7, 32'd9);
        wait_done();
        @(posedge clk); #1;
        issue(DIVU_AC, 32'd50, 32'd5);
        for (int n = 0; n < 100 && !done; n++) begin
            check("busy_lo_held", lo, 32'd63);
            check("busy_hi_held", hi, 32'd0);
            @(posedge clk); #1;
        end
        check("div50_done", done, 1);
        @(posedge clk); #1;

        // Random operands, including small divisors and b=1
        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i == 0) ? 32'd1 : ((i % 2) ? $urandom : $urandom_range(1, 1000));
            issue((i % 3 == 0) ? MULTU_AC : DIVU_AC, x, y);
            wait_done();
        end
        @(posedge clk); #1;

        // Reset mid-operation discards the op
        issue(DIVU_AC, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("midrst_no_busy", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
